// File: rtl/spi_master.sv
// SPI master: one addr/rw/data frame per start, MSB first.
// sclk idles low; miso sampled and mosi advanced on each sclk fall.
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int FW = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FW + 1);
  localparam logic [CW-1:0] DLAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(FW - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, SHIFT, HOLD
  } state_t;

  state_t                state, stateN;
  logic [CW-1:0]         cnt, cntN;
  logic [BW-1:0]         bitCnt, bitN;
  logic [FW-1:0]         txSh, txN;
  logic [DATA_WIDTH-1:0] rxSh, rxN;
  logic                  rwQ, rwN;
  logic                  busyN, doneN;
  logic                  sclkN, csN, mosiN;
  logic [DATA_WIDTH-1:0] rdataN;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitCnt <= '0;
      txSh   <= '0;
      rxSh   <= '0;
      rwQ    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      sclk   <= 1'b0;
      cs_n   <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      state  <= stateN;
      cnt    <= cntN;
      bitCnt <= bitN;
      txSh   <= txN;
      rxSh   <= rxN;
      rwQ    <= rwN;
      busy   <= busyN;
      done   <= doneN;
      rdata  <= rdataN;
      sclk   <= sclkN;
      cs_n   <= csN;
      mosi   <= mosiN;
    end
  end

  always_comb begin
    stateN = state;
    cntN   = cnt;
    bitN   = bitCnt;
    txN    = txSh;
    rxN    = rxSh;
    rwN    = rwQ;
    busyN  = busy;
    doneN  = 1'b0;
    rdataN = rdata;
    sclkN  = sclk;
    csN    = cs_n;
    mosiN  = mosi;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          rwN    = rw;
          txN    = {addr, rw,
                    rw ? {DATA_WIDTH{1'b0}} : wdata};
          stateN = LOAD;
        end
      end
      LOAD: begin
        stateN = SETUP;
        csN    = 1'b0;
        busyN  = 1'b1;
        mosiN  = txSh[FW-1];
        cntN   = '0;
        bitN   = '0;
      end
      SETUP: begin
        if (cnt == DLAST) begin
          cntN   = '0;
          sclkN  = 1'b1;
          stateN = SHIFT;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == DLAST) begin
          cntN = '0;
          if (sclk) begin
            sclkN = 1'b0;
            rxN   = {rxSh[DATA_WIDTH-2:0], miso};
            txN   = txSh << 1;
            bitN  = bitCnt + 1'b1;
            if (bitCnt == BLAST) begin
              mosiN  = 1'b0;
              stateN = HOLD;
            end else begin
              mosiN = txSh[FW-2];
            end
          end else begin
            sclkN = 1'b1;
          end
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == DLAST) begin
          cntN   = '0;
          csN    = 1'b1;
          busyN  = 1'b0;
          doneN  = 1'b1;
          stateN = IDLE;
          if (rwQ) rdataN = rxSh;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      default: stateN = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances with CLK_DIV 1..4.
// Expected frames, read data and done cycles go through a queue.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] start, rw, miso;
  logic [3:0] busy, done, sclk, csN, mosi;
  logic [6:0] addr [4];
  logic [7:0] wdata [4];
  logic [7:0] rdata [4];

  for (genvar g = 0; g < 4; g++) begin : gDut
    spi_master #(
      .CLK_DIV(g + 1),
      .ADDR_WIDTH(7),
      .DATA_WIDTH(8)
    ) dut (
      .clk(clk),
      .reset(reset),
      .start(start[g]),
      .rw(rw[g]),
      .addr(addr[g]),
      .wdata(wdata[g]),
      .busy(busy[g]),
      .done(done[g]),
      .rdata(rdata[g]),
      .sclk(sclk[g]),
      .cs_n(csN[g]),
      .mosi(mosi[g]),
      .miso(miso[g])
    );
  end

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rd;
    int          doneCyc;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  logic [7:0] lastRd [4];

  // drive one frame's operands at a negedge and queue its expectation
  task automatic launch(input int i, input logic r,
                        input logic [6:0] a, input logic [7:0] w,
                        input logic [7:0] sd);
    exp_t e;
    rw[i] = r;
    addr[i] = a;
    wdata[i] = w;
    start[i] = 1'b1;
    e.frame = {a, r, r ? 8'h00 : w};
    if (r) lastRd[i] = sd;
    e.rd = lastRd[i];
    e.doneCyc = 33 * (i + 1) + 1;
    sbq.push_back(e);
  endtask

  task automatic observeFrame(input int i, input int skip,
                              input bit hold, input int poke,
                              input logic [7:0] sd);
    int d;
    int rises, r1, r2, csLow, firstLow, busyCnt, doneCyc;
    logic [15:0] bits;
    logic prevS;
    exp_t e;
    d = i + 1;
    rises = 0; r1 = -1; r2 = -1;
    csLow = 0; firstLow = -1; busyCnt = 0; doneCyc = -1;
    bits = '0;
    prevS = 1'b0;
    miso[i] = 1'b0;
    repeat (skip) begin
      @(negedge clk);
      checks++;
      if (csN[i] !== 1'b1 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL gap inst%0d: cs_n=%b done=%b want 1/0",
                 i, csN[i], done[i]);
      end
    end
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
    checks++;
    if (csN[i] !== 1'b1 || busy[i] !== 1'b0) begin
      errors++;
      $display("FAIL cycle0 inst%0d: cs_n=%b busy=%b want 1/0",
               i, csN[i], busy[i]);
    end
    for (int cyc = 1; cyc <= 40 * d + 10 && doneCyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == poke) begin
        start[i] = 1'b1;
        addr[i] = ~addr[i];
      end else if (poke > 0 && cyc == poke + 1) begin
        start[i] = 1'b0;
      end
      if (!csN[i]) begin
        csLow++;
        if (firstLow < 0) firstLow = cyc;
      end
      if (busy[i]) busyCnt++;
      if (sclk[i] && !prevS) begin
        rises++;
        if (rises <= 16) bits[16-rises] = mosi[i];
        if (rises == 1) r1 = cyc;
        if (rises == 2) r2 = cyc;
        if (rises >= 9 && rises <= 16) miso[i] = sd[16-rises];
        else miso[i] = 1'($urandom_range(1));
      end
      prevS = sclk[i];
      if (done[i]) doneCyc = cyc;
    end
    miso[i] = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (doneCyc < 0) begin
      errors++;
      $display("FAIL timeout inst%0d: no done within %0d cycles",
               i, 40 * d + 10);
      return;
    end
    if (doneCyc != e.doneCyc) begin
      errors++;
      $display("FAIL doneCycle inst%0d: got %0d want %0d",
               i, doneCyc, e.doneCyc);
    end
    checks++;
    if (rises != 16) begin
      errors++;
      $display("FAIL riseCount inst%0d: got %0d want 16", i, rises);
    end
    checks++;
    if (bits !== e.frame) begin
      errors++;
      $display("FAIL frameBits inst%0d: got %b want %b",
               i, bits, e.frame);
    end
    checks++;
    if (r1 != 1 + d || r2 - r1 != 2 * d) begin
      errors++;
      $display("FAIL sclkTiming inst%0d: rise1=%0d period=%0d want %0d/%0d",
               i, r1, r2 - r1, 1 + d, 2 * d);
    end
    checks++;
    if (firstLow != 1 || csLow != 33 * d) begin
      errors++;
      $display("FAIL csWindow inst%0d: first=%0d len=%0d want 1/%0d",
               i, firstLow, csLow, 33 * d);
    end
    checks++;
    if (busyCnt != 33 * d || busy[i] !== 1'b0) begin
      errors++;
      $display("FAIL busyWindow inst%0d: len=%0d endBusy=%b want %0d/0",
               i, busyCnt, busy[i], 33 * d);
    end
    checks++;
    if (rdata[i] !== e.rd) begin
      errors++;
      $display("FAIL rdata inst%0d: got %h want %h", i, rdata[i], e.rd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = '0; rw = '0; miso = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      lastRd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy[i], done[i], sclk[i], csN[i], mosi[i]} !== 5'b00010
          || rdata[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset inst%0d: b/d/s/cs/m=%b%b%b%b%b rdata=%h want 00010/00",
                 i, busy[i], done[i], sclk[i], csN[i], mosi[i], rdata[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    @(negedge clk);
    launch(1, 1'b0, 7'h2A, 8'hC3, 8'h00);
    checks++;
    if (sbq[0].frame !== 16'b0101010_0_11000011) begin
      errors++;
      $display("FAIL writeFrameModel: got %b want 0101010011000011",
               sbq[0].frame);
    end
    observeFrame(1, 0, 1'b0, -1, 8'h00);
  endtask

  task automatic test_read();
    @(negedge clk);
    launch(3, 1'b1, 7'h05, 8'hFF, 8'h9E);
    observeFrame(3, 0, 1'b0, -1, 8'h9E);
  endtask

  task automatic test_timing();
    @(negedge clk);
    launch(0, 1'b0, 7'h7F, 8'h55, 8'h00);
    observeFrame(0, 0, 1'b0, -1, 8'h00);
    @(negedge clk);
    launch(2, 1'b0, 7'h11, 8'hA6, 8'h00);
    observeFrame(2, 0, 1'b0, -1, 8'h00);
    @(negedge clk);
    launch(0, 1'b1, 7'h40, 8'h00, 8'h5A);
    observeFrame(0, 0, 1'b0, -1, 8'h5A);
  endtask

  task automatic test_start_ignored();
    int extra, lowAfter;
    extra = 0; lowAfter = 0;
    @(negedge clk);
    launch(1, 1'b0, 7'h33, 8'h81, 8'h00);
    observeFrame(1, 0, 1'b0, 10, 8'h00);
    repeat (80) begin
      @(negedge clk);
      if (done[1]) extra++;
      if (!csN[1]) lowAfter++;
    end
    checks++;
    if (extra != 0 || lowAfter != 0) begin
      errors++;
      $display("FAIL startIgnored: extraDone=%0d csLow=%0d want 0/0",
               extra, lowAfter);
    end
  endtask

  task automatic test_reset_midframe();
    int extra;
    extra = 0;
    @(negedge clk);
    launch(1, 1'b0, 7'h0F, 8'hF0, 8'h00);
    void'(sbq.pop_back());
    @(negedge clk);
    start[1] = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (csN[1] !== 1'b0) begin
      errors++;
      $display("FAIL preReset: cs_n=%b want 0", csN[1]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) lastRd[i] = '0;
    checks++;
    if ({csN[1], sclk[1], busy[1], done[1], mosi[1]} !== 5'b10000) begin
      errors++;
      $display("FAIL midReset: cs/s/b/d/m=%b%b%b%b%b want 10000",
               csN[1], sclk[1], busy[1], done[1], mosi[1]);
    end
    repeat (80) begin
      @(negedge clk);
      if (done[1] || !csN[1]) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL postReset: %0d active/done cycles want 0", extra);
    end
    launch(1, 1'b0, 7'h5C, 8'h3E, 8'h00);
    observeFrame(1, 0, 1'b0, -1, 8'h00);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    launch(1, 1'b0, 7'h15, 8'h3C, 8'h00);
    observeFrame(1, 0, 1'b1, -1, 8'h00);
    launch(1, 1'b1, 7'h6B, 8'h00, 8'hE7);
    observeFrame(1, 1, 1'b0, -1, 8'hE7);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timing();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
